sram_mem_controller: RTL and testbench

//  MEM-stage data-memory controller: the producer side of the MEM/WB register inputs (mem_read_data_in).

---
 rtl/mem_pkg.sv | 12 +
 rtl/sram_addr_map.sv | 19 +
 rtl/sram_mem_controller.sv | 119 +++++++++++
 tb/tb_sram_mem_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;
  localparam int unsigned SRAM_DQ_W         = 16;
endpackage

// File: rtl/sram_addr_map.sv
// rtl/sram_addr_map.sv - byte address to SRAM halfword address translation
module sram_addr_map
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic [31:0]            address_i,
  input  logic                   half_sel_i,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o
);
  logic [31:0] offset;
  logic        unused_offset_bits;

  // Modulo-2^32 offset; byte lane bits and bits above the SRAM range wrap away.
  assign offset             = address_i - BASE_ADDR;
  assign sram_addr_o        = {offset[SRAM_ADDR_W:2], half_sel_i};
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
endmodule

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - splits 32-bit loads/stores into two 16-bit SRAM accesses
module sram_mem_controller
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DQ_W-1:0]   sram_dq_out,
  input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  localparam int unsigned    CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   store_q, store_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d, addr_lo, addr_hi;
  logic [SRAM_DQ_W-1:0]   dq_out_q, dq_out_d;
  logic                   oe_q, oe_d, we_n_q, we_n_d;
  logic                   req, last;

  assign req  = rd_en | wr_en;
  assign last = (cnt_q == CNT_LAST);

  sram_addr_map #(.BASE_ADDR(BASE_ADDR), .SRAM_ADDR_W(SRAM_ADDR_W)) u_map_lo (
    .address_i(address), .half_sel_i(1'b0), .sram_addr_o(addr_lo)
  );
  sram_addr_map #(.BASE_ADDR(BASE_ADDR), .SRAM_ADDR_W(SRAM_ADDR_W)) u_map_hi (
    .address_i(address), .half_sel_i(1'b1), .sram_addr_o(addr_hi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        cnt_d   = '0;
        store_d = wr_en;
      end
      LOW: if (last) begin
        state_d = HIGH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      HIGH: if (last) begin
        state_d = DONE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are driven from flops, so their next values follow the next state.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    read_data_d = read_data_q;
    oe_d        = 1'b0;
    we_n_d      = 1'b1;
    if (state_d == LOW) begin
      sram_addr_d = addr_lo;
      dq_out_d    = write_data[15:0];
      oe_d        = store_d;
      we_n_d      = ~store_d;
    end else if (state_d == HIGH) begin
      sram_addr_d = addr_hi;
      dq_out_d    = write_data[31:16];
      oe_d        = store_d;
      we_n_d      = ~store_d;
    end
    if (!store_q && last) begin
      if (state_q == LOW)  read_data_d[15:0]  = sram_dq_in;
      if (state_q == HIGH) read_data_d[31:16] = sram_dq_in;
    end
  end

  assign ready       = ~req | (state_q == DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - scoreboard bench for sram_mem_controller with SRAM model
module tb_sram_mem_controller;
  localparam int AC = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en, wr_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  logic          rd1;
  logic [31:0]   read_data1;
  logic          ready1;
  logic [AW-1:0] sram_addr1;
  logic [15:0]   dq_out1, dq_in1;
  logic          oe1, we_n1;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [15:0]   shadow [int];
  logic [31:0]   exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  sram_mem_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(AW), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .rd_en(rd1), .wr_en(1'b0), .address(32'd1024),
    .write_data(32'd0), .read_data(read_data1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(oe1), .sram_we_n(we_n1)
  );

  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr];
  assign dq_in1     = sram_addr1[15:0] ^ 16'h5A5A;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int hw(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) >> 2;
    return int'((w & ((32'd1 << (AW - 1)) - 1)) << 1);
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
    int k;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    if (wr) begin
      shadow[hw(a)]     = d[15:0];
      shadow[hw(a) + 1] = d[31:16];
    end else if (rd) begin
      exp_q.push_back({shadow[hw(a) + 1], shadow[hw(a)]});
    end
    k = 0;
    #1;
    while (!ready && k < 20) begin
      if (k >= 1) begin
        chk("we_n", {31'd0, sram_we_n}, {31'd0, !wr});
        chk("oe", {31'd0, sram_dq_oe}, {31'd0, wr});
        chk("addr", {14'd0, sram_addr}, hw(a) + ((k > AC) ? 1 : 0));
        if (wr) chk("dq_out", {16'd0, sram_dq_out}, {16'd0, (k <= AC) ? d[15:0] : d[31:16]});
      end
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, 2 * AC + 1);
    chk("we_n_done", {31'd0, sram_we_n}, 32'd1);
    if (rd && !wr) chk("rdata", read_data, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0; rd1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);

    // reset arriving in the second LOW cycle of a store
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    #1;
    chk("mid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_rdata", read_data, 32'd0);
    chk("mid_addr", {14'd0, sram_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF); idle();
    chk("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    chk("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1024, 32'd0); idle();
    chk("load0", read_data, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'd1028, 32'h12345678); idle();
    chk("mem2", {16'd0, mem[2]}, 32'h00005678);
    chk("mem3", {16'd0, mem[3]}, 32'h00001234);
    access(1'b1, 1'b0, 32'd1031, 32'd0); idle();
    chk("load1031", read_data, 32'h12345678);

    access(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5); idle();
    chk("mem4", {16'd0, mem[4]}, 32'h0000A5A5);
    chk("mem5", {16'd0, mem[5]}, 32'h0000A5A5);
    chk("both_rdata", read_data, 32'h12345678);

    // back-to-back loads, each sees one IDLE bubble before LOW
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    access(1'b1, 1'b0, 32'd1028, 32'd0);
    idle();
    chk("b2b_rdata", read_data, 32'h12345678);
    chk("sb_empty", exp_q.size(), 0);

    // single-cycle accesses held back to back: ready every 4th cycle
    @(negedge clk);
    rd1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("ac1_ready", {31'd0, ready1}, {31'd0, (c % 4) == 3});
      if ((c % 4) == 3) chk("ac1_rdata", read_data1, 32'h5A5B5A5A);
      @(negedge clk);
    end
    rd1 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
